// File: rtl/interface_fifo.sv
// First-word-fall-through buffer with full/empty status and occupancy count.
// Optional sticky dropped-write detection is built when OVERRUN_DETECT_EN is defined.
module interface_fifo #(
  parameter int N = 8,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic         rd,
  input  logic [N-1:0] data_in,
`ifdef OVERRUN_DETECT_EN
  input  logic         clr_ovr,
  output logic         overrun,
`endif
  output logic [N-1:0] data_out,
  output logic         status_flag,
  output logic         empty,
  output logic         full,
  output logic [W:0]   count
);

  localparam int         DEPTH   = 2 ** W;
  localparam logic [W:0] DEPTH_C = (W + 1)'(DEPTH);

  logic [N-1:0] mem_r [DEPTH];
  logic [W-1:0] wr_ptr_r;
  logic [W-1:0] rd_ptr_r;
  logic [W:0]   count_r;
  logic         empty_r;
  logic         full_r;
  logic [N-1:0] data_out_r;

  logic         wr_acc_s;
  logic         rd_acc_s;
  logic [W-1:0] rd_ptr_nxt_s;
  logic [W:0]   count_nxt_s;
  logic [N-1:0] head_nxt_s;

  assign wr_acc_s = wr & (~full_r | rd);
  assign rd_acc_s = rd & ~empty_r;

  // Next pointer, occupancy and head word; the head bypasses the array when
  // the word being written this cycle becomes the new head.
  always_comb begin
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    head_nxt_s   = '0;
    if (rd_acc_s) begin
      rd_ptr_nxt_s = rd_ptr_r + W'(1'b1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    if (wr_acc_s && !rd_acc_s) begin
      count_nxt_s = count_r + (W + 1)'(1'b1);
    end else if (rd_acc_s && !wr_acc_s) begin
      count_nxt_s = count_r - (W + 1)'(1'b1);
    end else begin
      count_nxt_s = count_r;
    end
    if (count_nxt_s == (W + 1)'(1'b0)) begin
      head_nxt_s = '0;
    end else if (wr_acc_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = data_in;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Storage array write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // Pointers, occupancy and registered status/head outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
      data_out_r <= '0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + W'(1'b1);
      end
      rd_ptr_r   <= rd_ptr_nxt_s;
      count_r    <= count_nxt_s;
      empty_r    <= (count_nxt_s == (W + 1)'(1'b0));
      full_r     <= (count_nxt_s == DEPTH_C);
      data_out_r <= head_nxt_s;
    end
  end

`ifdef OVERRUN_DETECT_EN
  logic overrun_r;

  // Sticky dropped-write flag; a new drop outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_r <= 1'b0;
    end else if (wr && full_r && !rd) begin
      overrun_r <= 1'b1;
    end else if (clr_ovr) begin
      overrun_r <= 1'b0;
    end
  end

  assign overrun = overrun_r;
`endif

  assign data_out    = data_out_r;
  assign status_flag = ~empty_r;
  assign empty       = empty_r;
  assign full        = full_r;
  assign count       = count_r;

endmodule

// File: tb/tb_interface_fifo.sv
// Scoreboard bench for interface_fifo: a queue model of buffer contents is
// updated as stimulus is driven and popped against data_out on every read.
module tb_interface_fifo;

  localparam int N     = 8;
  localparam int W     = 2;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr;
  logic         rd;
  logic [N-1:0] data_in;
  logic [N-1:0] data_out;
  logic         status_flag;
  logic         empty;
  logic         full;
  logic [W:0]   count;
`ifdef OVERRUN_DETECT_EN
  logic         clr_ovr;
  logic         overrun;
  logic         ovr_exp;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [N-1:0] model_q[$];

  interface_fifo #(.N(N), .W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr          (wr),
    .rd          (rd),
    .data_in     (data_in),
`ifdef OVERRUN_DETECT_EN
    .clr_ovr     (clr_ovr),
    .overrun     (overrun),
`endif
    .data_out    (data_out),
    .status_flag (status_flag),
    .empty       (empty),
    .full        (full),
    .count       (count)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; updates the model and pops/compares the head on reads.
  task automatic cycle(input logic w, input logic r, input logic [N-1:0] d, input logic c = 1'b0);
    bit acc_w, acc_r;
    acc_r = r && (model_q.size() > 0);
    acc_w = w && ((model_q.size() < DEPTH) || r);
    wr = w; rd = r; data_in = d;
`ifdef OVERRUN_DETECT_EN
    clr_ovr = c;
    if (w && !r && model_q.size() == DEPTH) ovr_exp = 1'b1;
    else if (c) ovr_exp = 1'b0;
`endif
    if (acc_r) begin
      vectors++;
      if (data_out !== model_q[0]) begin
        miscompares++;
        $display("FAIL read_data: got %h expected %h", data_out, model_q[0]);
      end
      void'(model_q.pop_front());
    end
    if (acc_w) model_q.push_back(d);
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0; data_in = '0;
`ifdef OVERRUN_DETECT_EN
    clr_ovr = 1'b0;
`endif
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_q.delete();
`ifdef OVERRUN_DETECT_EN
    ovr_exp = 1'b0;
`endif
    vectors++;
    if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || status_flag !== 1'b0 || data_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_state: got count=%0d empty=%b full=%b flag=%b dout=%h expected 0 1 0 0 00",
               count, empty, full, status_flag, data_out);
    end
  endtask

  task automatic test_single_word;
    cycle(1'b1, 1'b0, 8'hA5);
    vectors++;
    if (data_out !== 8'hA5 || count !== 3'd1 || status_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL single_write: got dout=%h count=%0d flag=%b expected a5 1 1", data_out, count, status_flag);
    end
    cycle(1'b0, 1'b1, 8'h00);
    vectors++;
    if (empty !== 1'b1 || data_out !== 8'h00 || status_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL single_read: got empty=%b dout=%h flag=%b expected 1 00 0", empty, data_out, status_flag);
    end
  endtask

  task automatic test_fill_drain;
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 1'b0, N'(i));
    vectors++;
    if (full !== 1'b1 || count !== 3'd4 || data_out !== 8'h01) begin
      miscompares++;
      $display("FAIL fill: got full=%b count=%0d dout=%h expected 1 4 01", full, count, data_out);
    end
    cycle(1'b1, 1'b0, 8'h05);
    vectors++;
    if (full !== 1'b1 || count !== 3'd4 || data_out !== 8'h01) begin
      miscompares++;
      $display("FAIL drop_when_full: got full=%b count=%0d dout=%h expected 1 4 01", full, count, data_out);
    end
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'h00);
    vectors++;
    if (empty !== 1'b1 || count !== 3'd0 || data_out !== 8'h00) begin
      miscompares++;
      $display("FAIL drain: got empty=%b count=%0d dout=%h expected 1 0 00", empty, count, data_out);
    end
  endtask

  task automatic test_simultaneous;
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, N'(8'h11 + i));
    cycle(1'b1, 1'b1, 8'h55);
    vectors++;
    if (count !== 3'd4 || full !== 1'b1 || data_out !== 8'h12) begin
      miscompares++;
      $display("FAIL wr_rd_full: got count=%0d full=%b dout=%h expected 4 1 12", count, full, data_out);
    end
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b1, 1'b1, 8'h66);
    vectors++;
    if (count !== 3'd1 || empty !== 1'b0 || data_out !== 8'h66) begin
      miscompares++;
      $display("FAIL wr_rd_empty: got count=%0d empty=%b dout=%h expected 1 0 66", count, empty, data_out);
    end
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 8'h00);
    vectors++;
    if (count !== 3'd0 || empty !== 1'b1 || data_out !== 8'h00) begin
      miscompares++;
      $display("FAIL rd_on_empty: got count=%0d empty=%b dout=%h expected 0 1 00", count, empty, data_out);
    end
    cycle(1'b1, 1'b0, 8'h77);
    vectors++;
    if (count !== 3'd1 || data_out !== 8'h77) begin
      miscompares++;
      $display("FAIL after_empty_rd: got count=%0d dout=%h expected 1 77", count, data_out);
    end
    cycle(1'b0, 1'b1, 8'h00);
  endtask

  task automatic test_wrap;
    cycle(1'b1, 1'b0, 8'h7E);
    cycle(1'b1, 1'b0, 8'h7F);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, (i % 3) != 2, N'(8'h80 + i));
      vectors++;
      if (count !== (W + 1)'(model_q.size())) begin
        miscompares++;
        $display("FAIL wrap_count[%0d]: got %0d expected %0d", i, count, model_q.size());
      end
    end
    while (model_q.size() > 0) cycle(1'b0, 1'b1, 8'h00);
    vectors++;
    if (empty !== 1'b1 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL wrap_drain: got empty=%b count=%0d expected 1 0", empty, count);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 60; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), N'($urandom));
      vectors++;
      if (count !== (W + 1)'(model_q.size()) || full !== (model_q.size() == DEPTH) ||
          empty !== (model_q.size() == 0)) begin
        miscompares++;
        $display("FAIL random_state[%0d]: got count=%0d full=%b empty=%b expected count=%0d",
                 i, count, full, empty, model_q.size());
      end
    end
  endtask

  task automatic test_reset_mid_op;
    cycle(1'b1, 1'b0, 8'hC1);
    cycle(1'b1, 1'b0, 8'hC2);
    test_reset();
    vectors++;
    if (count !== 3'd0 || data_out !== 8'h00 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset: got count=%0d dout=%h empty=%b expected 0 00 1", count, data_out, empty);
    end
    cycle(1'b1, 1'b0, 8'hD4);
    cycle(1'b0, 1'b1, 8'h00);
  endtask

`ifdef OVERRUN_DETECT_EN
  task automatic test_overrun;
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, N'(8'hE0 + i));
    cycle(1'b1, 1'b0, 8'hEE);
    cycle(1'b0, 1'b0, 8'h00);
    vectors++;
    if (overrun !== 1'b1 || overrun !== ovr_exp) begin
      miscompares++;
      $display("FAIL overrun_set: got %b expected 1", overrun);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_clear: got %b expected 0", overrun);
    end
    cycle(1'b1, 1'b0, 8'hEF, 1'b1);
    vectors++;
    if (overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_set_wins: got %b expected 1", overrun);
    end
    while (model_q.size() > 0) cycle(1'b0, 1'b1, 8'h00);
  endtask
`endif

  initial begin
    reset = 1'b1; wr = 1'b0; rd = 1'b0; data_in = '0;
`ifdef OVERRUN_DETECT_EN
    clr_ovr = 1'b0;
`endif
    test_reset();
    test_single_word();
    test_fill_drain();
    test_simultaneous();
    test_wrap();
    test_back_to_back();
    test_reset_mid_op();
`ifdef OVERRUN_DETECT_EN
    test_overrun();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
